// File: rtl/main_memory.sv
// Word-addressed main memory responder for the cache's memory port.
// A strobe edge starts an access; done pulses after latency and strobe release.
module main_memory #(
  parameter int MEM_ADDR_SIZE = 10,
  parameter int WORD_SIZE_BIT = 32,
  parameter int LATENCY       = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [MEM_ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE_BIT-1:0] wData,
  output logic [WORD_SIZE_BIT-1:0] memData,
  output logic                     done_r,
  output logic                     done_w
);

  localparam int IW    = MEM_ADDR_SIZE - 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  logic [WORD_SIZE_BIT-1:0] mem [DEPTH];

  logic [1:0]               state;
  logic [7:0]               cnt;
  logic                     op_wr;
  logic [IW-1:0]            idx;
  logic [WORD_SIZE_BIT-1:0] wdata_q;
  logic                     read_q;
  logic                     write_q;

  logic rd_req;
  logic wr_req;
  logic strobe;
  logic unused_addr;

  assign rd_req      = read & ~read_q;
  assign wr_req      = write & ~write_q;
  assign strobe      = op_wr ? write : read;
  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      done_r  <= 1'b0;
      done_w  <= 1'b0;
      memData <= '0;
    end else begin
      read_q  <= read;
      write_q <= write;
      done_r  <= 1'b0;
      done_w  <= 1'b0;
      case (state)
        IDLE: begin
          // write wins a same-edge collision; the read edge is lost
          if (wr_req) begin
            op_wr   <= 1'b1;
            idx     <= addr[MEM_ADDR_SIZE-1:2];
            wdata_q <= wData;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end else if (rd_req) begin
            op_wr <= 1'b0;
            idx   <= addr[MEM_ADDR_SIZE-1:2];
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state <= strobe ? WAIT_REL : DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WAIT_REL: begin
          if (!strobe) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (op_wr) begin
            done_w <= 1'b1;
          end else begin
            done_r  <= 1'b1;
            memData <= mem[idx];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // array is deliberately not reset; reset holds state in IDLE
  always_ff @(posedge clock) begin
    if (state == DONE && op_wr) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: vector table, corner
// sequences and a randomized run against a word-array model.
module tb_main_memory;

  localparam int L = 4;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [9:0]  addr;
  logic [31:0] wData;
  logic [31:0] memData;
  logic        done_r;
  logic        done_w;

  int tests;
  int fails;
  int cyc;

  logic [31:0] ref_mem [256];
  bit          ref_vld [256];

  main_memory #(
    .MEM_ADDR_SIZE(10),
    .WORD_SIZE_BIT(32),
    .LATENCY(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .read(read),
    .write(write),
    .addr(addr),
    .wData(wData),
    .memData(memData),
    .done_r(done_r),
    .done_w(done_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [9:0]  a;
    logic [31:0] d;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_edge(input int hold);
    return (hold + 1 > L + 1) ? hold + 1 : L + 1;
  endfunction

  // drives one access; edge k is counted from the edge sampling the rise
  task automatic access(input bit do_rd, input bit do_wr,
                        input logic [9:0] a, input logic [31:0] d,
                        input int hold,
                        output int nr, output int nw,
                        output int fr, output int fw,
                        output logic [31:0] rd_at);
    int lim;
    @(negedge clock);
    addr  = a;
    wData = d;
    read  = do_rd;
    write = do_wr;
    nr = 0; nw = 0; fr = -1; fw = -1; rd_at = 'x;
    lim = exp_edge(hold) + 3;
    for (int k = 0; k < lim; k++) begin
      @(negedge clock);
      if (k == hold - 1) begin
        read  = 1'b0;
        write = 1'b0;
      end
      if (done_r) begin
        nr++;
        if (fr < 0) begin
          fr    = k;
          rd_at = memData;
        end
      end
      if (done_w) begin
        nw++;
        if (fw < 0) fw = k;
      end
    end
  endtask

  task automatic do_write(input string nm, input logic [9:0] a,
                          input logic [31:0] d, input int hold);
    int nr, nw, fr, fw;
    logic [31:0] rd, md;
    md = memData;
    access(1'b0, 1'b1, a, d, hold, nr, nw, fr, fw, rd);
    chk({nm, "_done_w_edge"}, fw, exp_edge(hold));
    chk({nm, "_done_w_cnt"}, nw, 1);
    chk({nm, "_no_done_r"}, nr, 0);
    chk({nm, "_memdata_kept"}, memData, md);
    ref_mem[a[9:2]] = d;
    ref_vld[a[9:2]] = 1'b1;
  endtask

  task automatic do_read(input string nm, input logic [9:0] a,
                         input int hold, input logic [31:0] exp);
    int nr, nw, fr, fw;
    logic [31:0] rd;
    access(1'b1, 1'b0, a, 32'h0, hold, nr, nw, fr, fw, rd);
    chk({nm, "_done_r_edge"}, fr, exp_edge(hold));
    chk({nm, "_done_r_cnt"}, nr, 1);
    chk({nm, "_no_done_w"}, nw, 0);
    chk({nm, "_data"}, rd, exp);
  endtask

  initial begin
    int nr, nw, fr, fw, st, base;
    bit got, bad;
    logic [31:0] rd;
    logic [9:0] ra;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wData = '0;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;

    vt[0]  = '{1, 10'h040, 32'hDEADBEEF, 3, 32'h0};
    vt[1]  = '{0, 10'h040, 32'h0, 3, 32'hDEADBEEF};
    vt[2]  = '{1, 10'h100, 32'h1, 3, 32'h0};
    vt[3]  = '{1, 10'h104, 32'h2, 3, 32'h0};
    vt[4]  = '{1, 10'h108, 32'h3, 3, 32'h0};
    vt[5]  = '{1, 10'h10C, 32'h4, 3, 32'h0};
    vt[6]  = '{1, 10'h043, 32'h12345678, 3, 32'h0};
    vt[7]  = '{0, 10'h040, 32'h0, 3, 32'h12345678};
    vt[8]  = '{0, 10'h040, 32'h0, 10, 32'h12345678};
    vt[9]  = '{1, 10'h0C0, 32'h11112222, 2, 32'h0};
    vt[10] = '{0, 10'h0C2, 32'h0, 2, 32'h11112222};
    vt[11] = '{0, 10'h10C, 32'h0, 6, 32'h4};

    #12;
    chk("reset_memdata", memData, 32'h0);
    chk("reset_done_r", done_r, 1'b0);
    chk("reset_done_w", done_w, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) do_write($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].hold);
      else do_read($sformatf("vec%0d", i), vt[i].a, vt[i].hold, vt[i].exp);
    end

    access(1'b1, 1'b1, 10'h080, 32'hA5A5A5A5, 3, nr, nw, fr, fw, rd);
    chk("coll_done_w_edge", fw, L + 1);
    chk("coll_done_w_cnt", nw, 1);
    chk("coll_no_done_r", nr, 0);
    ref_mem[8'h20] = 32'hA5A5A5A5;
    ref_vld[8'h20] = 1'b1;
    do_read("coll_read", 10'h080, 3, 32'hA5A5A5A5);

    // back-to-back refill: next strobe rises right after each done
    @(negedge clock);
    addr = 10'h100;
    read = 1'b1;
    base = cyc + 1;
    st   = base;
    for (int w = 0; w < 4; w++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clock);
        if (cyc - st == 2) read = 1'b0;
        if (done_r) begin
          got = 1'b1;
          chk($sformatf("burst%0d_edge", w), cyc - base, 6 * w + 5);
          chk($sformatf("burst%0d_data", w), memData, 32'(w + 1));
          if (w < 3) begin
            addr = 10'h100 + 10'(4 * (w + 1));
            read = 1'b1;
            st   = cyc + 1;
          end
        end
      end
      if (!got) chk($sformatf("burst%0d_timeout", w), 0, 1);
    end
    @(negedge clock);
    chk("burst_done_fall", done_r, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = {8'($urandom_range(16, 47)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1 || !ref_vld[ra[9:2]])
        do_write($sformatf("rnd%0d_w", i), ra, $urandom, $urandom_range(2, 8));
      else
        do_read($sformatf("rnd%0d_r", i), ra, $urandom_range(2, 8), ref_mem[ra[9:2]]);
    end

    do_read("pre_rst_read", 10'h0C0, 3, 32'h11112222);
    @(negedge clock);
    addr  = 10'h0C0;
    wData = 32'hCAFEF00D;
    write = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_memdata", memData, 32'h0);
    chk("rst_mid_done_r", done_r, 1'b0);
    chk("rst_mid_done_w", done_w, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 1) write = 1'b0;
      if (done_r || done_w) bad = 1'b1;
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (done_r || done_w) bad = 1'b1;
    end
    chk("rst_no_done", bad, 1'b0);
    do_read("post_rst_read", 10'h0C0, 3, 32'h11112222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
